// File: rtl/axi_burst_master.sv
// AXI4 INCR burst master: one command in flight, streaming W/R data, one completion pulse per command.
// Optional 4 KB boundary rejection is enabled by defining AXI_MASTER_4K_CHECK_EN.
module axi_burst_master #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 128,
    parameter int AXI_ID_WIDTH   = 16,
    parameter int MAX_BURST_LEN  = 256
) (
    input  logic                        s_axi_aclk,
    input  logic                        s_axi_areset,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_rw,
    input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [7:0]                  cmd_len,
    input  logic [AXI_ID_WIDTH-1:0]     cmd_id,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [AXI_DATA_WIDTH-1:0]   wr_data,
    input  logic [AXI_DATA_WIDTH/8-1:0] wr_strb,
    output logic                        rd_valid,
    input  logic                        rd_ready,
    output logic [AXI_DATA_WIDTH-1:0]   rd_data,
    output logic                        rd_last,
    output logic [1:0]                  rd_resp,
    output logic                        done_valid,
    output logic [1:0]                  done_resp,
    output logic [AXI_ID_WIDTH-1:0]     done_id,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [AXI_ID_WIDTH-1:0]     m_axi_awid,
    output logic [7:0]                  m_axi_awlen,
    output logic [2:0]                  m_axi_awsize,
    output logic [1:0]                  m_axi_awburst,
    output logic                        m_axi_awvalid,
    input  logic                        m_axi_awready,
    output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                        m_axi_wlast,
    output logic                        m_axi_wvalid,
    input  logic                        m_axi_wready,
    input  logic [AXI_ID_WIDTH-1:0]     m_axi_bid,
    input  logic [1:0]                  m_axi_bresp,
    input  logic                        m_axi_bvalid,
    output logic                        m_axi_bready,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [AXI_ID_WIDTH-1:0]     m_axi_arid,
    output logic [7:0]                  m_axi_arlen,
    output logic [2:0]                  m_axi_arsize,
    output logic [1:0]                  m_axi_arburst,
    output logic                        m_axi_arvalid,
    input  logic                        m_axi_arready,
    input  logic [AXI_ID_WIDTH-1:0]     m_axi_rid,
    input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                  m_axi_rresp,
    input  logic                        m_axi_rlast,
    input  logic                        m_axi_rvalid,
    output logic                        m_axi_rready
);
    localparam int SIZE = $clog2(AXI_DATA_WIDTH/8);

    typedef enum logic [2:0] {IDLE, AW, W, B, AR, R, DONE} state_t;

    state_t                    r_state;
    logic [AXI_ADDR_WIDTH-1:0] r_addr;
    logic [7:0]                r_len;
    logic [7:0]                r_cnt;
    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [AXI_ID_WIDTH-1:0]   r_done_id;
    logic [1:0]                r_resp;
    logic                      r_awvalid;
    logic                      r_arvalid;
    logic                      r_bready;
    logic                      r_done;

    logic w_len_bad;
    logic w_bad4k;
    logic w_reject;
    logic w_whs;
    logic w_rhs;

    assign w_len_bad = (32'(cmd_len) > 32'(MAX_BURST_LEN - 1));

`ifdef AXI_MASTER_4K_CHECK_EN
    logic [AXI_ADDR_WIDTH-1:0] w_bytes;
    logic [AXI_ADDR_WIDTH-1:0] w_end;
    assign w_bytes = (AXI_ADDR_WIDTH'(cmd_len) + AXI_ADDR_WIDTH'(1)) << SIZE;
    assign w_end   = cmd_addr + w_bytes - AXI_ADDR_WIDTH'(1);
    assign w_bad4k = (cmd_addr[AXI_ADDR_WIDTH-1:12] != w_end[AXI_ADDR_WIDTH-1:12]);
`else
    assign w_bad4k = 1'b0;
`endif

    assign w_reject = w_len_bad | w_bad4k;

    // Reset is folded in so cmd_ready reads 0 while reset is held.
    assign cmd_ready = (r_state == IDLE) & ~s_axi_areset;

    assign m_axi_awaddr  = r_addr;
    assign m_axi_awid    = r_id;
    assign m_axi_awlen   = r_len;
    assign m_axi_awsize  = 3'(SIZE);
    assign m_axi_awburst = 2'b01;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_araddr  = r_addr;
    assign m_axi_arid    = r_id;
    assign m_axi_arlen   = r_len;
    assign m_axi_arsize  = 3'(SIZE);
    assign m_axi_arburst = 2'b01;
    assign m_axi_arvalid = r_arvalid;
    assign m_axi_bready  = r_bready;

    assign m_axi_wvalid = (r_state == W) & wr_valid;
    assign wr_ready     = (r_state == W) & m_axi_wready;
    assign m_axi_wdata  = wr_data;
    assign m_axi_wstrb  = wr_strb;
    assign m_axi_wlast  = (r_cnt == r_len);
    assign w_whs        = m_axi_wvalid & m_axi_wready;

    assign rd_valid     = (r_state == R) & m_axi_rvalid;
    assign m_axi_rready = (r_state == R) & rd_ready;
    assign rd_data      = m_axi_rdata;
    assign rd_last      = m_axi_rlast;
    assign rd_resp      = m_axi_rresp;
    assign w_rhs        = rd_valid & m_axi_rready;

    assign done_valid = r_done;
    assign done_resp  = r_resp;
    assign done_id    = r_done_id;

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_id      <= '0;
            r_done_id <= '0;
            r_resp    <= 2'b00;
            r_awvalid <= 1'b0;
            r_arvalid <= 1'b0;
            r_bready  <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (cmd_valid) begin
                    r_addr <= cmd_addr;
                    r_len  <= cmd_len;
                    r_id   <= cmd_id;
                    r_cnt  <= '0;
                    r_resp <= 2'b00;
                    if (w_reject) begin
                        r_resp    <= 2'b10;
                        r_done_id <= cmd_id;
                        r_done    <= 1'b1;
                        r_state   <= DONE;
                    end else if (cmd_rw) begin
                        r_awvalid <= 1'b1;
                        r_state   <= AW;
                    end else begin
                        r_arvalid <= 1'b1;
                        r_state   <= AR;
                    end
                end
                AW: if (m_axi_awready) begin
                    r_awvalid <= 1'b0;
                    r_state   <= W;
                end
                W: if (w_whs) begin
                    if (r_cnt == r_len) begin
                        r_bready <= 1'b1;
                        r_state  <= B;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                B: if (m_axi_bvalid) begin
                    r_bready  <= 1'b0;
                    r_resp    <= m_axi_bresp;
                    r_done_id <= m_axi_bid;
                    r_done    <= 1'b1;
                    r_state   <= DONE;
                end
                AR: if (m_axi_arready) begin
                    r_arvalid <= 1'b0;
                    r_state   <= R;
                end
                R: if (w_rhs) begin
                    // Keep the first error seen in the burst.
                    if (r_resp == 2'b00) r_resp <= m_axi_rresp;
                    if (m_axi_rlast) begin
                        r_done_id <= m_axi_rid;
                        r_done    <= 1'b1;
                        r_state   <= DONE;
                    end
                end
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
